// File: rtl/siso_pkg.sv
// Shared types and constants for the SISO transmit scheduler and its arbiter.
package siso_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_PAR   = 2'd2
    } siso_state_t;

    localparam int   SISO_N = 8;
    localparam logic REQ0   = 1'b0;
    localparam logic REQ1   = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: one-hot grant, pointer flips away from the winner on advance.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    // r_ptr=1 means requester 1 wins the next tie
    logic r_ptr;

    always_comb begin
        grant = req;
        if (req == 2'b11) grant = r_ptr ? 2'b10 : 2'b01;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)         r_ptr <= 1'b0;
        else if (advance) r_ptr <= grant[0];
    end

endmodule

// File: rtl/siso_tx_sched.sv
// Two-requester round-robin scheduler feeding an MSB-first serial link.
// SISO_PARITY_EN appends an even-parity bit as a final PAR frame bit.
module siso_tx_sched
    import siso_pkg::*;
#(
    parameter int N = SISO_N
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_valid,
    input  logic [N-1:0] req0_data,
    output logic         req0_ready,
    input  logic         req1_valid,
    input  logic [N-1:0] req1_data,
    output logic         req1_ready,
    input  logic         s_ready,
    output logic         s_out,
    output logic         s_valid,
    output logic         s_last,
    output logic         s_id,
    output logic         busy
);

    localparam int CW = $clog2(N+1);

    siso_state_t  r_state, w_next;
    logic [N-1:0] r_sr;
    logic [CW-1:0] r_cnt;
    logic          r_id;
    logic [1:0]    w_req, w_grant;
    logic          w_hs, w_cnt_zero;
    logic [N-1:0]  w_load;

    // Requests are masked in reset so no ready can leak out while rst is low
    assign w_req      = {req1_valid, req0_valid} & {2{(r_state == ST_IDLE) && rst}};
    assign w_hs       = |w_grant;
    assign w_cnt_zero = (r_cnt == '0);
    assign w_load     = w_grant[1] ? req1_data : req0_data;

    rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (w_req),
        .advance (w_hs),
        .grant   (w_grant)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= ST_IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_hs) w_next = ST_SHIFT;
            ST_SHIFT: if (s_ready && w_cnt_zero) begin
`ifdef SISO_PARITY_EN
                w_next = ST_PAR;
`else
                w_next = ST_IDLE;
`endif
            end
`ifdef SISO_PARITY_EN
            ST_PAR:   if (s_ready) w_next = ST_IDLE;
`endif
            default:  w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sr  <= '0;
            r_cnt <= '0;
            r_id  <= REQ0;
        end else if (w_hs) begin
            r_sr  <= w_load;
            r_cnt <= CW'(N-1);
            r_id  <= w_grant[1] ? REQ1 : REQ0;
        end else if ((r_state == ST_SHIFT) && s_ready) begin
            r_sr  <= {r_sr[N-2:0], 1'b0};
            if (!w_cnt_zero) r_cnt <= r_cnt - 1'b1;
        end
    end

`ifdef SISO_PARITY_EN
    logic r_par;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)      r_par <= 1'b0;
        else if (w_hs) r_par <= ^w_load;
    end
`endif

    assign req0_ready = w_grant[0];
    assign req1_ready = w_grant[1];
    assign s_valid    = (r_state != ST_IDLE);
    assign busy       = (r_state != ST_IDLE);
    assign s_id       = r_id;

    always_comb begin
        s_out  = 1'b0;
        s_last = 1'b0;
        case (r_state)
            ST_SHIFT: begin
                s_out = r_sr[N-1];
`ifndef SISO_PARITY_EN
                s_last = w_cnt_zero;
`endif
            end
`ifdef SISO_PARITY_EN
            ST_PAR: begin
                s_out  = r_par;
                s_last = 1'b1;
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: tb/tb_siso_tx_sched.sv
// Directed bench for siso_tx_sched; a scoreboard of expected serial bits is filled on each handshake.
module tb_siso_tx_sched;

    localparam int N = 8;
`ifdef SISO_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         req0_valid, req1_valid, req0_ready, req1_ready;
    logic [N-1:0] req0_data, req1_data;
    logic         s_ready, s_out, s_valid, s_last, s_id, busy;

    typedef struct packed { logic b; logic last; logic id; } exp_t;
    exp_t sbq[$];
    exp_t mon_e;
    int   hs_id[$];
    int   hs_cyc[$];
    int   cyc_cnt = 0;
    int   n_tests = 0;
    int   n_fail  = 0;

    siso_tx_sched #(.N(N)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
        .s_ready(s_ready), .s_out(s_out), .s_valid(s_valid), .s_last(s_last),
        .s_id(s_id), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_frame(input logic [N-1:0] d, input logic id);
        for (int i = N-1; i >= 0; i--)
            sbq.push_back('{b: d[i], last: (i == 0) && (PAR == 0), id: id});
        if (PAR != 0) sbq.push_back('{b: ^d, last: 1'b1, id: id});
    endtask

    // Monitor: record handshakes into the scoreboard, retire bits as the link takes them
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (req0_ready || req1_ready) begin
                chk("one_ready", {30'd0, req1_ready, req0_ready} & 32'h3, req1_ready ? 32'h2 : 32'h1);
                chk("ready_idle", {31'd0, busy}, 32'd0);
            end
            if (req0_valid && req0_ready) begin
                push_frame(req0_data, 1'b0); hs_id.push_back(0); hs_cyc.push_back(cyc_cnt);
            end
            if (req1_valid && req1_ready) begin
                push_frame(req1_data, 1'b1); hs_id.push_back(1); hs_cyc.push_back(cyc_cnt);
            end
            if (s_valid && s_ready) begin
                if (sbq.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
                else begin
                    mon_e = sbq.pop_front();
                    chk("s_out",  {31'd0, s_out},  {31'd0, mon_e.b});
                    chk("s_last", {31'd0, s_last}, {31'd0, mon_e.last});
                    chk("s_id",   {31'd0, s_id},   {31'd0, mon_e.id});
                end
            end
        end
    end

    task automatic step;
        @(posedge clk); #1;
    endtask

    task automatic wait_idle(input string tag);
        int k;
        for (k = 0; k < 60; k++) begin
            @(negedge clk); #2;
            if (!busy && sbq.size() == 0) break;
        end
        chk(tag, {31'd0, (k < 60)}, 32'd1);
    endtask

    task automatic wait_hs(input int cnt, input string tag);
        int k;
        for (k = 0; k < 80; k++) begin
            @(negedge clk); #2;
            if (hs_id.size() >= cnt) break;
        end
        chk(tag, {31'd0, (k < 80)}, 32'd1);
    endtask

    initial begin
        logic [15:0] pat;
        rst = 1'b0; s_ready = 1'b1;
        req0_valid = 1'b1; req0_data = 8'hFF;
        req1_valid = 1'b0; req1_data = '0;

        // Reset state: all outputs low even with a valid request pending
        repeat (3) step();
        chk("reset_outs", {26'd0, req0_ready, req1_ready, s_out, s_valid, s_last, busy}, 32'd0);
        chk("reset_id", {31'd0, s_id}, 32'd0);

        // Lone requester 0, word A5
        rst = 1'b1; req0_valid = 1'b1; req0_data = 8'hA5;
        @(negedge clk);
        chk("t1_ready", {31'd0, req0_ready}, 32'd1);
        for (int c = 1; c <= N + PAR; c++) begin
            step();
            req0_valid = 1'b0;
            @(negedge clk);
            chk("t1_busy", {31'd0, busy}, 32'd1);
        end
        @(negedge clk);
        chk("t1_idle", {31'd0, busy}, 32'd0);
        chk("t1_sb", sbq.size(), 32'd0);

        // Both valid from reset: order 0,1,0
        step(); rst = 1'b0; step(); rst = 1'b1;
        hs_id.delete(); hs_cyc.delete();
        req0_valid = 1'b1; req0_data = 8'h0F;
        req1_valid = 1'b1; req1_data = 8'hF0;
        wait_hs(3, "t2_timeout");
        step(); req0_valid = 1'b0; req1_valid = 1'b0;
        chk("t2_id0", hs_id[0], 32'd0);
        chk("t2_id1", hs_id[1], 32'd1);
        chk("t2_id2", hs_id[2], 32'd0);
        wait_idle("t2_drain");

        // Stalls on the fourth bit and on the last data bit
        step(); req0_valid = 1'b1; req0_data = 8'h81;
        @(negedge clk);
        chk("t3_ready", {31'd0, req0_ready}, 32'd1);
        pat = 16'hC78F;
        for (int c = 1; c <= 14 + PAR; c++) begin
            step();
            req0_valid = 1'b0;
            s_ready = pat[c];
            @(negedge clk);
            if (c >= 4 && c <= 6)
                chk("t3_stall_a", {29'd0, s_valid, s_out, s_last}, 32'b100);
            if (c >= 11 && c <= 13)
                chk("t3_stall_b", {29'd0, s_valid, s_out, s_last}, {29'd0, 1'b1, 1'b1, (PAR == 0)});
            if (c == 14 + PAR) chk("t3_busy_end", {31'd0, busy}, 32'd1);
        end
        step(); s_ready = 1'b1;
        @(negedge clk);
        chk("t3_idle", {31'd0, busy}, 32'd0);

        // Reset mid-frame aborts; pointer returns to requester 0
        step(); req0_valid = 1'b1; req0_data = 8'hC3;
        @(negedge clk);
        chk("t4_ready", {31'd0, req0_ready}, 32'd1);
        step(); req0_valid = 1'b0;
        repeat (3) step();
        rst = 1'b0; req0_valid = 1'b1; req1_valid = 1'b1;
        req0_data = 8'h3C; req1_data = 8'h5A;
        #1;
        chk("t4_async_outs", {26'd0, req0_ready, req1_ready, s_out, s_valid, s_last, busy}, 32'd0);
        chk("t4_async_id", {31'd0, s_id}, 32'd0);
        sbq.delete();
        repeat (2) step();
        rst = 1'b1;
        @(negedge clk);
        chk("t4_ptr", {30'd0, req1_ready, req0_ready}, 32'b01);
        step(); req0_valid = 1'b0; req1_valid = 1'b0;
        wait_idle("t4_drain");

        // Parity words (plain data frames without parity)
        step(); req0_valid = 1'b1; req0_data = 8'h07;
        step(); req0_valid = 1'b0;
        wait_idle("t5a_drain");
        step(); req0_valid = 1'b1; req0_data = 8'h03;
        step(); req0_valid = 1'b0;
        wait_idle("t5b_drain");

        // Requester 1 alone: back-to-back every N+1(+parity) cycles
        hs_id.delete(); hs_cyc.delete();
        step(); req1_valid = 1'b1; req1_data = 8'h96;
        wait_hs(3, "t6_timeout");
        step(); req1_valid = 1'b0;
        chk("t6_gap1", hs_cyc[1] - hs_cyc[0], N + 1 + PAR);
        chk("t6_gap2", hs_cyc[2] - hs_cyc[1], N + 1 + PAR);
        chk("t6_id", hs_id[0] + hs_id[1] + hs_id[2], 32'd3);
        wait_idle("t6_drain");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/siso_tx_sched.md
Name: siso_tx_sched

Overview:
- Two-requester scheduler for the team's serial-in/serial-out shift channel.
- Accepts N-bit parallel words from two clients over valid/ready handshakes and arbitrates between them round-robin.
- Loads the granted word and shifts it out MSB-first, one bit per cycle, with frame qualifiers.
- Sits between local producers and the single serial link that feeds downstream SISO chains.

Parameters:
N, 8, data word width in bits (N >= 2)
CW, $clog2(N+1), bit-counter width (derived localparam, not overridable)

Ports:
clk  input  1  system clock, all state on posedge
rst  input  1  asynchronous active-low reset (0 = reset)
req0_valid  input  1  requester 0 has a word
req0_data  input  N  requester 0 word
req0_ready  output  1  requester 0 word accepted this cycle
req1_valid  input  1  requester 1 has a word
req1_data  input  N  requester 1 word
req1_ready  output  1  requester 1 word accepted this cycle
s_ready  input  1  downstream can take a bit this cycle
s_out  output  1  serial data bit
s_valid  output  1  s_out is a valid frame bit
s_last  output  1  final bit of the current frame
s_id  output  1  owner of the current frame (0/1)
busy  output  1  a frame is in progress

Behaviour:
- Reset (rst=0, async): state=IDLE, shift register=0, bit counter=0, rr pointer selects requester 0 first, s_id=0. All outputs are 0 while in reset.
- FSM states: IDLE, SHIFT, and PAR (PAR exists only with SISO_PARITY_EN).
- IDLE:
  - reqX_ready = grant to X, combinational from reqX_valid, the pointer and state==IDLE.
  - If only one requester is valid, it is granted. If both are valid, the requester not served last is granted.
  - At most one ready is high per cycle. Both readies are 0 outside IDLE.
  - On a handshake: load the shift register with the data, set counter = N-1, set s_id = X, set the pointer so the other requester is preferred next, then go to SHIFT.
- SHIFT:
  - s_valid=1, s_out = shift register MSB, busy=1.
  - When s_ready=1: shift left by 1 and decrement the counter.
  - When s_ready=0: all state holds and s_out/s_valid stay stable (stall).
  - s_last=1 when counter==0 and parity is disabled.
  - On counter==0 with s_ready=1: go to IDLE (parity disabled) or PAR (parity enabled).
- Latency: a word accepted in cycle T drives its MSB on s_out in cycle T+1. An unstalled frame occupies N cycles (N+1 with parity). There is a minimum 1-cycle IDLE gap between frames, so peak throughput is N bits per N+1 cycles.
- busy=1 in SHIFT and PAR, 0 in IDLE. s_id is stable for the whole frame and holds its last value in IDLE.
- Boundaries:
  - A requester dropping valid while not granted is legal; there is no state change.
  - Data presented while busy is ignored until IDLE.
  - s_ready=0 on the last bit holds s_last high until that bit is accepted.
  - Reset mid-frame aborts the frame immediately; the partial frame is not resumed.
  - A lone repeated requester is granted back-to-back every N+1 cycles. The pointer only matters when both requesters are valid.

Optional Feature:
- Macro: SISO_PARITY_EN
- Defined:
  - Even-parity tracking register = XOR of the loaded word, captured at load.
  - After the N data bits the FSM enters PAR: s_out = parity, s_valid=1, s_last=1. s_last is 0 during SHIFT.
  - PAR holds under s_ready=0 and exits to IDLE when s_ready=1.
  - Frame is N+1 bits.
- Undefined: PAR state and parity register are absent; frame is N bits with s_last on data bit 0.

Decomposition:
- Shared package siso_pkg holds:
  - the FSM state encoding typedef (IDLE/SHIFT/PAR);
  - default width constant SISO_N=8;
  - requester-id constants REQ0=0 and REQ1=1.
- One natural sub-module: rr_arb2, a 2-way round-robin arbiter.
  - Inputs: clk, rst, req[1:0], advance.
  - Output: one-hot grant[1:0].
  - Owns the pointer; advance = handshake fired.
  - Reused later for other shared serial resources.

Test Plan:
1. N=8, only req0_valid with 0xA5, s_ready=1 -> req0_ready high 1 cycle; s_out = 1,0,1,0,0,1,0,1 on cycles T+1..T+8; s_last only on cycle T+8; s_id=0; busy low at T+9.
2. Both valid from reset (req0=0x0F, req1=0xF0, held) -> req0 served first, then req1, then req0; s_id toggles 0,1,0; never two readies in one cycle.
3. Frame 0x81 with s_ready=0 for 3 cycles on bit 3 and on the last bit -> s_out/s_valid/s_last held stable during stalls; frame completes in 8 + 3 + 3 cycles.
4. Assert rst=0 mid-frame (after 4 bits), release 2 cycles later -> outputs 0 asynchronously; the next accepted word starts a fresh frame from its MSB; the pointer is back to requester 0.
5. SISO_PARITY_EN, word 0x07 -> 8 data bits with s_last=0, then a ninth bit s_out=1 with s_last=1; word 0x03 gives parity bit 0.
6. req1 valid continuously, req0 never -> req1 accepted every 9 cycles (N=8, no parity) with exactly one IDLE gap cycle.
